// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: requester handshake and registered common-data-bus signals of the writeback arbiter
interface cdb_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ROB_W = 4
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*ROB_W-1:0] req_rob_id;
  logic [N_REQ*32-1:0]    req_value;
  logic [N_REQ-1:0]       req_ready;
  logic                   cdb_valid;
  logic [ROB_W-1:0]       cdb_rob_id;
  logic [31:0]            cdb_value;
  logic [2:0]             cdb_src;
  modport master (
    output req_valid, req_rob_id, req_value,
    input  req_ready, cdb_valid, cdb_rob_id, cdb_value, cdb_src
  );
  modport slave (
    input  req_valid, req_rob_id, req_value,
    output req_ready, cdb_valid, cdb_rob_id, cdb_value, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-requester holding slots, round-robin grant onto a registered CDB feeding the ROB write port.
// Define CDB_FIXED_PRIO_EN to replace round-robin with lowest-index-wins fixed priority.
module cdb_arbiter #(
  parameter int N_REQ = 4,
  parameter int ROB_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  cdb_arbiter_if.slave     bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  logic [N_REQ-1:0] slot_v_q, slot_v_d, grant, acc;
  logic [ROB_W-1:0] slot_id_q [N_REQ];
  logic [ROB_W-1:0] slot_id_d [N_REQ];
  logic [31:0]      slot_val_q [N_REQ];
  logic [31:0]      slot_val_d [N_REQ];
  logic [PW-1:0]    base, idx;
  logic [2:0]       g_idx;
  logic             any_g, active;
  logic             cdb_valid_q, cdb_valid_d;
  logic [ROB_W-1:0] cdb_id_q, cdb_id_d;
  logic [31:0]      cdb_val_q, cdb_val_d;
  logic [2:0]       cdb_src_q, cdb_src_d;
  // Reset is folded in so req_ready drops the moment reset asserts, not at the next edge.
  assign active        = rdy_in && !clear_in && !rst_in;
  assign bus.req_ready = {N_REQ{active}} & (~slot_v_q | grant);
  assign bus.cdb_valid  = cdb_valid_q;
  assign bus.cdb_rob_id = cdb_id_q;
  assign bus.cdb_value  = cdb_val_q;
  assign bus.cdb_src    = cdb_src_q;
  // Scan from the highest offset down so the last hit is the first occupied slot after base.
  always_comb begin
    any_g = 1'b0;
    g_idx = '0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(base) + k) % N_REQ);
      if (slot_v_q[idx]) begin
        any_g = 1'b1;
        g_idx = 3'(idx);
      end
    end
    for (int i = 0; i < N_REQ; i++) grant[i] = any_g && (g_idx == 3'(i));
  end
  always_comb begin
    acc         = bus.req_valid & bus.req_ready;
    cdb_valid_d = any_g;
    cdb_id_d    = cdb_id_q;
    cdb_val_d   = cdb_val_q;
    cdb_src_d   = any_g ? g_idx : cdb_src_q;
    for (int i = 0; i < N_REQ; i++) begin
      slot_v_d[i]   = acc[i] | (slot_v_q[i] & ~grant[i]);
      slot_id_d[i]  = acc[i] ? bus.req_rob_id[i*ROB_W +: ROB_W] : slot_id_q[i];
      slot_val_d[i] = acc[i] ? bus.req_value[i*32 +: 32] : slot_val_q[i];
      cdb_id_d      = grant[i] ? slot_id_q[i] : cdb_id_d;
      cdb_val_d     = grant[i] ? slot_val_q[i] : cdb_val_d;
    end
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      slot_v_q    <= '0;
      slot_id_q   <= '{default: '0};
      slot_val_q  <= '{default: '0};
      cdb_valid_q <= 1'b0;
      cdb_id_q    <= '0;
      cdb_val_q   <= '0;
      cdb_src_q   <= '0;
    end else if (rdy_in) begin
      slot_v_q    <= clear_in ? '0 : slot_v_d;
      cdb_valid_q <= clear_in ? 1'b0 : cdb_valid_d;
      slot_id_q   <= slot_id_d;
      slot_val_q  <= slot_val_d;
      if (!clear_in) begin
        cdb_id_q  <= cdb_id_d;
        cdb_val_q <= cdb_val_d;
        cdb_src_q <= cdb_src_d;
      end
    end
  end
`ifdef CDB_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [PW-1:0] ptr_q, ptr_d;
  assign ptr_d = (g_idx == 3'(N_REQ - 1)) ? '0 : PW'(g_idx + 3'd1);
  assign base  = ptr_q;
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) ptr_q <= '0;
    else if (rdy_in) ptr_q <= clear_in ? '0 : (any_g ? ptr_d : ptr_q);
  end
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of the CDB writeback arbiter (round-robin build)
module tb_cdb_arbiter;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;
  logic clear_in = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [39:0] cdb;
  cdb_arbiter_if #(.N_REQ(4), .ROB_W(4)) bus ();
  cdb_arbiter #(.N_REQ(4), .ROB_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in), .bus(bus)
  );
  always #5 clk_in = ~clk_in;
  assign cdb = {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value, bus.cdb_src};
  task tick;
    @(posedge clk_in);
    #1;
  endtask
  task apply_reset;
    rst_in = 1'b1;
    #2;
    rst_in = 1'b0;
    tick();
  endtask
  task test_reset;
    #1;
    checks++;
    if (cdb !== 40'h0) begin errors++; $display("FAIL reset_cdb: got %h exp %h", cdb, 40'h0); end
    checks++;
    if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready_low: got %b exp 0000", bus.req_ready); end
    tick();
    rst_in = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'hF) begin errors++; $display("FAIL reset_ready_rise: got %b exp 1111", bus.req_ready); end
  endtask
  task test_single;
    bus.req_valid  = 4'b0100;
    bus.req_rob_id = 16'h0500;
    bus.req_value  = {32'h0, 32'hDEADBEEF, 64'h0};
    #1;
    checks++;
    if (bus.req_ready[2] !== 1'b1) begin errors++; $display("FAIL single_ready: got %b exp 1", bus.req_ready[2]); end
    tick();
    bus.req_valid = 4'b0;
    checks++;
    if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL single_latency: got %b exp 0", bus.cdb_valid); end
    tick();
    checks++;
    if (cdb !== {1'b1, 4'd5, 32'hDEADBEEF, 3'd2}) begin
      errors++; $display("FAIL single_cdb: got %h exp %h", cdb, {1'b1, 4'd5, 32'hDEADBEEF, 3'd2});
    end
    tick();
    checks++;
    if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL single_drop: got %b exp 0", bus.cdb_valid); end
  endtask
  task test_contention;
    apply_reset();
    bus.req_valid  = 4'hF;
    bus.req_rob_id = 16'h3210;
    bus.req_value  = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    tick();
    bus.req_valid = 4'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (cdb !== {1'b1, 4'(i), 32'hC0 + 32'(i), 3'(i)}) begin
        errors++; $display("FAIL contention_%0d: got %h exp %h", i, cdb, {1'b1, 4'(i), 32'hC0 + 32'(i), 3'(i)});
      end
    end
    tick();
    checks++;
    if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL contention_idle: got %b exp 0", bus.cdb_valid); end
  endtask
  task test_back_to_back;
    for (int c = 0; c < 6; c++) begin
      bus.req_valid  = 4'b0010;
      bus.req_rob_id = {8'h0, 4'(c + 1), 4'h0};
      bus.req_value  = {64'h0, 32'(100 + c), 32'h0};
      #1;
      checks++;
      if (bus.req_ready[1] !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b exp 1", c, bus.req_ready[1]); end
      tick();
      if (c > 0) begin
        checks++;
        if (cdb !== {1'b1, 4'(c), 32'(99 + c), 3'd1}) begin
          errors++; $display("FAIL b2b_cdb_%0d: got %h exp %h", c, cdb, {1'b1, 4'(c), 32'(99 + c), 3'd1});
        end
      end
    end
    bus.req_valid = 4'b0;
    tick();
    checks++;
    if (cdb !== {1'b1, 4'd6, 32'd105, 3'd1}) begin
      errors++; $display("FAIL b2b_last: got %h exp %h", cdb, {1'b1, 4'd6, 32'd105, 3'd1});
    end
    tick();
    checks++;
    if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b exp 0", bus.cdb_valid); end
  endtask
  task test_flush;
    bus.req_valid  = 4'b1001;
    bus.req_rob_id = 16'h9008;
    bus.req_value  = {32'h99, 64'h0, 32'h88};
    tick();
    bus.req_valid = 4'b0;
    clear_in = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL flush_ready: got %b exp 0000", bus.req_ready); end
    tick();
    clear_in = 1'b0;
    checks++;
    if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_cdb: got %b exp 0", bus.cdb_valid); end
    tick();
    checks++;
    if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_slots_empty: got %b exp 0", bus.cdb_valid); end
    bus.req_valid  = 4'b1010;
    bus.req_rob_id = 16'hB0A0;
    bus.req_value  = {32'h33, 32'h0, 32'h11, 32'h0};
    tick();
    bus.req_valid = 4'b0;
    tick();
    checks++;
    if (cdb !== {1'b1, 4'hA, 32'h11, 3'd1}) begin
      errors++; $display("FAIL flush_ptr0_first: got %h exp %h", cdb, {1'b1, 4'hA, 32'h11, 3'd1});
    end
    tick();
    checks++;
    if (cdb !== {1'b1, 4'hB, 32'h33, 3'd3}) begin
      errors++; $display("FAIL flush_ptr0_second: got %h exp %h", cdb, {1'b1, 4'hB, 32'h33, 3'd3});
    end
    tick();
    bus.req_valid  = 4'b0100;
    bus.req_rob_id = 16'h0C00;
    bus.req_value  = {32'h0, 32'h22, 64'h0};
    tick();
    bus.req_valid = 4'b0;
    rdy_in   = 1'b0;
    clear_in = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL frozen_clear_ready: got %b exp 0000", bus.req_ready); end
    tick();
    tick();
    rdy_in   = 1'b1;
    clear_in = 1'b0;
    tick();
    checks++;
    if (cdb !== {1'b1, 4'hC, 32'h22, 3'd2}) begin
      errors++; $display("FAIL frozen_clear_kept: got %h exp %h", cdb, {1'b1, 4'hC, 32'h22, 3'd2});
    end
    tick();
  endtask
  task test_freeze;
    bus.req_valid  = 4'b0011;
    bus.req_rob_id = 16'h0067;
    bus.req_value  = {64'h0, 32'h66, 32'h77};
    tick();
    bus.req_valid = 4'b0;
    tick();
    checks++;
    if (cdb !== {1'b1, 4'd7, 32'h77, 3'd0}) begin
      errors++; $display("FAIL freeze_pre: got %h exp %h", cdb, {1'b1, 4'd7, 32'h77, 3'd0});
    end
    rdy_in = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL freeze_ready: got %b exp 0000", bus.req_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (cdb !== {1'b1, 4'd7, 32'h77, 3'd0}) begin
        errors++; $display("FAIL freeze_hold_%0d: got %h exp %h", i, cdb, {1'b1, 4'd7, 32'h77, 3'd0});
      end
    end
    rdy_in = 1'b1;
    tick();
    checks++;
    if (cdb !== {1'b1, 4'd6, 32'h66, 3'd1}) begin
      errors++; $display("FAIL freeze_release: got %h exp %h", cdb, {1'b1, 4'd6, 32'h66, 3'd1});
    end
    tick();
  endtask
  task test_async_reset;
    bus.req_valid  = 4'hF;
    bus.req_rob_id = 16'h4321;
    bus.req_value  = {32'h44, 32'h33, 32'h22, 32'h11};
    tick();
    bus.req_valid = 4'b0;
    tick();
    checks++;
    if (bus.cdb_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: got %b exp 1", bus.cdb_valid); end
    #2;
    rst_in = 1'b1;
    #1;
    checks++;
    if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL areset_cdb: got %b exp 0", bus.cdb_valid); end
    checks++;
    if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL areset_ready: got %b exp 0000", bus.req_ready); end
    #2;
    rst_in = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'hF) begin errors++; $display("FAIL areset_ready_rise: got %b exp 1111", bus.req_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL areset_stale_%0d: got %b exp 0", i, bus.cdb_valid); end
    end
  endtask
  initial begin
    bus.req_valid  = '0;
    bus.req_rob_id = '0;
    bus.req_value  = '0;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_flush();
    test_freeze();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
